// File: rtl/vga_sync_receiver_if.sv
// vga_sync_receiver_if: video stream, sample port and status bundle between a VGA source and the receiver.
interface vga_sync_receiver_if;
  logic        pix_en;
  logic        hSync;
  logic        vSync;
  logic        bright;
  logic [7:0]  rgb;
  logic        sample_req;
  logic [9:0]  sample_x;
  logic [9:0]  sample_y;
  logic        err_clr;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        pixel_valid;
  logic [9:0]  line_len;
  logic [15:0] frame_count;
  logic        locked;
  logic        err_hlen;
  logic        err_vlen;
  logic        sample_ack;
  logic [7:0]  sample_rgb;
  modport master (
    output pix_en, hSync, vSync, bright, rgb, sample_req, sample_x, sample_y, err_clr,
    input  x, y, pixel_valid, line_len, frame_count, locked, err_hlen, err_vlen, sample_ack, sample_rgb
  );
  modport slave (
    input  pix_en, hSync, vSync, bright, rgb, sample_req, sample_x, sample_y, err_clr,
    output x, y, pixel_valid, line_len, frame_count, locked, err_hlen, err_vlen, sample_ack, sample_rgb
  );
endinterface

// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver: recovers pixel coordinates, line/frame timing and lock from a VGA stream,
// and captures the rgb value at a requested pixel.
module vga_sync_receiver #(
  parameter int H_TOTAL     = 801,
  parameter int V_TOTAL     = 522,
  parameter int LOCK_FRAMES = 2
) (
  input logic clk,
  input logic clear,
  vga_sync_receiver_if.slave bus
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t r_state, w_next;
  logic r_d_hs, r_q_hs, r_d_vs, r_q_vs, r_d_bright;
  logic [7:0] r_d_rgb, r_sample_rgb;
  logic [9:0] r_hcnt, r_vcnt, r_line_len, r_x, r_y, r_sx, r_sy;
  logic [15:0] r_frame_count;
  logic [3:0] r_good_run;
  logic r_h_seen, r_v_seen, r_bad, r_err_h, r_err_v, r_y_pend, r_new_line, r_ack;
  logic w_hfall, w_vfall, w_locked, w_hbad, w_vmeas, w_vbad, w_good, w_hit;
  logic [9:0] w_lines;
  assign w_hfall  = bus.pix_en & r_q_hs & ~r_d_hs;
  assign w_vfall  = bus.pix_en & r_q_vs & ~r_d_vs;
  assign w_locked = r_good_run == 4'(LOCK_FRAMES);
  assign w_hbad   = w_hfall & r_h_seen & (r_hcnt != 10'(H_TOTAL));
  // an hfall coinciding with vfall closes the frame that is ending
  assign w_lines  = r_vcnt + {9'd0, w_hfall};
  assign w_vmeas  = w_vfall & r_v_seen;
  assign w_vbad   = w_vmeas & (w_lines != 10'(V_TOTAL));
  assign w_good   = ~(r_bad | w_hbad | w_vbad);
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      {r_d_hs, r_q_hs, r_d_vs, r_q_vs, r_d_bright} <= '0;
      r_d_rgb       <= '0;
      r_hcnt        <= '0;
      r_vcnt        <= '0;
      r_line_len    <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_frame_count <= '0;
      r_good_run    <= '0;
      {r_h_seen, r_v_seen, r_bad, r_err_h, r_err_v, r_y_pend, r_new_line} <= '0;
    end else begin
      r_err_h <= (w_hbad & w_locked) | (r_err_h & ~bus.err_clr);
      r_err_v <= (w_vbad & w_locked) | (r_err_v & ~bus.err_clr);
      if (bus.pix_en) begin
        r_d_hs     <= bus.hSync;
        r_q_hs     <= r_d_hs;
        r_d_vs     <= bus.vSync;
        r_q_vs     <= r_d_vs;
        r_d_bright <= bus.bright;
        r_d_rgb    <= bus.rgb;
        r_hcnt     <= w_hfall ? 10'd1 : (r_hcnt == 10'h3FF ? r_hcnt : r_hcnt + 10'd1);
        r_vcnt     <= w_vfall ? 10'd0 : (w_hfall && r_vcnt != 10'h3FF ? r_vcnt + 10'd1 : r_vcnt);
        r_bad      <= ~w_vfall & (r_bad | w_hbad);
        r_y_pend   <= w_vfall | (r_y_pend & ~bus.bright);
        r_new_line <= w_hfall | (r_new_line & ~bus.bright);
        if (w_hfall) r_h_seen <= 1'b1;
        if (w_vfall) r_v_seen <= 1'b1;
        if (w_hfall && r_h_seen) r_line_len <= r_hcnt;
        if (w_vmeas) r_frame_count <= r_frame_count + 16'd1;
        if (w_vmeas) r_good_run <= !w_good ? 4'd0 : (w_locked ? r_good_run : r_good_run + 4'd1);
        else if (w_hbad && w_locked) r_good_run <= 4'd0;
        // x restarts on each bright rising edge; y advances once per line that carries bright
        if (bus.bright) begin
          r_x <= !r_d_bright ? 10'd0 : (r_x == 10'h3FF ? r_x : r_x + 10'd1);
          r_y <= r_y_pend ? 10'd0 : (r_new_line && r_y != 10'h3FF ? r_y + 10'd1 : r_y);
        end
      end
    end
  end
  always_ff @(posedge clk or posedge clear) begin
    if (clear) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_hit  = (r_state == WAIT) & bus.pix_en & r_d_bright & (r_x == r_sx) & (r_y == r_sy) & ~bus.sample_req;
    w_next = bus.sample_req ? WAIT : (w_hit ? IDLE : r_state);
  end
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_sx         <= '0;
      r_sy         <= '0;
      r_ack        <= 1'b0;
      r_sample_rgb <= '0;
    end else begin
      r_ack <= w_hit;
      if (bus.sample_req) begin
        r_sx <= bus.sample_x;
        r_sy <= bus.sample_y;
      end
      if (w_hit) r_sample_rgb <= r_d_rgb;
    end
  end
  assign bus.x           = r_x;
  assign bus.y           = r_y;
  assign bus.pixel_valid = r_d_bright;
  assign bus.line_len    = r_line_len;
  assign bus.frame_count = r_frame_count;
  assign bus.locked      = w_locked;
  assign bus.err_hlen    = r_err_h;
  assign bus.err_vlen    = r_err_v;
  assign bus.sample_ack  = r_ack;
  assign bus.sample_rgb  = r_sample_rgb;
endmodule
